// File: rtl/alu_pkg.sv
// Shared ALU definitions: datapath width and the divider's FSM state encoding.
package alu_pkg;

    localparam int DATA_W = 16;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } div_state_t;

endpackage

// File: rtl/subtractor_ripple.sv
// Ripple-borrow subtractor: out = in_a - in_b - bin, bout is the final borrow.
module subtractor_ripple #(
    parameter int W = 17
) (
    input  logic [W-1:0] in_a,
    input  logic [W-1:0] in_b,
    input  logic         bin,
    output logic         bout,
    output logic [W-1:0] out
);

    logic [W:0] borrow;

    assign borrow[0] = bin;

    for (genvar i = 0; i < W; i++) begin : g_fs
        assign out[i]        = in_a[i] ^ in_b[i] ^ borrow[i];
        assign borrow[i + 1] = (~in_a[i] & in_b[i]) | (~(in_a[i] ^ in_b[i]) & borrow[i]);
    end

    assign bout = borrow[W];

endmodule

// File: rtl/divider16_seq.sv
// Iterative restoring unsigned divider: one quotient bit per cycle, valid/ready
// on both sides. A zero divisor bypasses the iteration and reports div-by-zero.
module divider16_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = DATA_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_dividend,
    input  logic [WIDTH-1:0] in_divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_quotient,
    output logic [WIDTH-1:0] out_remainder,
    output logic             out_div_zero
);

    localparam int CNT_W = $clog2(WIDTH);

    div_state_t       state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH:0]   r_q;
    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] dvs_q;
    logic             in_ready_q;
    logic             out_valid_q;
    logic [WIDTH-1:0] out_quotient_q;
    logic [WIDTH-1:0] out_remainder_q;
    logic             out_div_zero_q;

    logic [WIDTH:0]   r_shift;
    logic [WIDTH:0]   r_diff;
    logic             borrow;
    logic [WIDTH:0]   r_d;
    logic [WIDTH-1:0] q_d;

    // After a restoring step R < divisor, so its top bit never feeds the next shift.
    logic r_msb_unused;
    assign r_msb_unused = r_q[WIDTH];

    assign r_shift = {r_q[WIDTH-1:0], q_q[WIDTH-1]};

    subtractor_ripple #(
        .W (WIDTH + 1)
    ) u_sub (
        .in_a (r_shift),
        .in_b ({1'b0, dvs_q}),
        .bin  (1'b0),
        .bout (borrow),
        .out  (r_diff)
    );

    assign r_d = borrow ? r_shift : r_diff;
    assign q_d = {q_q[WIDTH-2:0], ~borrow};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= IDLE;
            cnt_q           <= '0;
            r_q             <= '0;
            q_q             <= '0;
            dvs_q           <= '0;
            in_ready_q      <= 1'b1;
            out_valid_q     <= 1'b0;
            out_quotient_q  <= '0;
            out_remainder_q <= '0;
            out_div_zero_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        r_q        <= '0;
                        q_q        <= in_dividend;
                        dvs_q      <= in_divisor;
                        cnt_q      <= '0;
                        in_ready_q <= 1'b0;
                        if (in_divisor == '0) begin
                            state_q         <= DONE;
                            out_valid_q     <= 1'b1;
                            out_quotient_q  <= '1;
                            out_remainder_q <= in_dividend;
                            out_div_zero_q  <= 1'b1;
                        end else begin
                            state_q <= CALC;
                        end
                    end
                end
                CALC: begin
                    r_q   <= r_d;
                    q_q   <= q_d;
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        state_q         <= DONE;
                        out_valid_q     <= 1'b1;
                        out_quotient_q  <= q_d;
                        out_remainder_q <= r_d[WIDTH-1:0];
                        out_div_zero_q  <= 1'b0;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready      = in_ready_q;
    assign out_valid     = out_valid_q;
    assign out_quotient  = out_quotient_q;
    assign out_remainder = out_remainder_q;
    assign out_div_zero  = out_div_zero_q;

endmodule
